// File: rtl/keynsham_uart_rx.sv
// -----------------------------------------------------------------------------
// keynsham_uart_rx
//
// 16x oversampling UART receiver (8 data bits, no parity, 1 stop bit) for the
// Keynsham UART bus peripheral. The asynchronous rx pad is synchronised, and
// its start edge is qualified at mid-bit. Data bits are then sampled at the
// centre of each bit period. Each good byte is presented on dout with a
// sticky rdy flag. The register block clears rdy (and both error flags) with
// a one-cycle rdy_clr pulse.
//
// Parameters
//   CLK_FREQ   core clock frequency in Hz
//   BAUD       line rate in bits per second
//
// Ports
//   clk        core clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   rx         serial input, idle high, asynchronous to clk
//   rdy_clr    one-cycle pulse: clears rdy, overrun and frame_err
//   rdy        sticky: a received byte is held in dout
//   dout       last received byte
//   overrun    sticky: a byte completed while rdy was already set
//   frame_err  sticky: the stop bit was sampled low
//
// All outputs come straight from flops, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module keynsham_uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic       rdy,
    output logic [7:0] dout,
    output logic       overrun,
    output logic       frame_err
);

    // Clocks per oversample tick. Integer truncation is intended: the small
    // rate error this introduces is absorbed by mid-bit sampling.
    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    // -------------------------------------------------------------------------
    // Input synchroniser. Both stages reset to the idle (high) level, so
    // leaving reset does not show a false start bit.
    // -------------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    // NOTE: non-blocking assignments make the two stages a real two-flop
    // chain. Blocking here would collapse them into one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Oversample tick generator. It free-runs from reset and is never
    // restarted by line activity. The start edge is therefore resolved to
    // within one tick. The mid-bit sampling point tolerates that error.
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             tick;

    assign tick = (div_cnt_q == DIV_LAST);

    // NOTE: the next-state value gets its default before any condition, so
    // every path assigns it and no latch can be inferred.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Receive state machine with registered outputs.
    //
    // samp_q counts ticks within a bit. In START it runs from the detected
    // edge to the bit centre (value 7). In DATA and STOP it runs a full 16
    // ticks, so that each sample falls one bit period after the previous
    // centre. It wraps naturally from 15 to 0, ready for the next bit.
    // -------------------------------------------------------------------------
    state_e      state_q;
    logic [3:0]  samp_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        rdy_q;
    logic [7:0]  dout_q;
    logic        overrun_q;
    logic        frame_err_q;

    // NOTE: the clear is written first and the set events after it. When
    // several non-blocking assignments hit the same flop in one edge, the
    // last one wins. A byte completion or framing error therefore overrides
    // a simultaneous rdy_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            samp_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rdy_q       <= 1'b0;
            dout_q      <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (rdy_clr) begin
                rdy_q       <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end

            if (tick) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (!rx_s_q) begin
                            samp_q  <= '0;
                            state_q <= S_START;
                        end
                    end

                    S_START: begin
                        if (samp_q == 4'd7) begin
                            // A start bit that is already gone at its centre
                            // was noise. Drop it without touching the flags.
                            if (rx_s_q) begin
                                state_q <= S_IDLE;
                            end else begin
                                samp_q    <= '0;
                                bit_cnt_q <= '0;
                                state_q   <= S_DATA;
                            end
                        end else begin
                            samp_q <= samp_q + 4'd1;
                        end
                    end

                    S_DATA: begin
                        samp_q <= samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            // The line sends LSB first. Shifting right with the
                            // new bit at the top leaves bit 0 in shift_q[0].
                            shift_q   <= {rx_s_q, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= S_STOP;
                            end
                        end
                    end

                    S_STOP: begin
                        samp_q <= samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            if (rx_s_q) begin
                                dout_q <= shift_q;
                                rdy_q  <= 1'b1;
                                // A byte that is being read in this same
                                // cycle counts as consumed, not overrun.
                                if (rdy_q && !rdy_clr) begin
                                    overrun_q <= 1'b1;
                                end
                                state_q <= S_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_WAIT_HIGH;
                            end
                        end
                    end

                    S_WAIT_HIGH: begin
                        // A break holds the line low. Wait until it returns
                        // high, so that a long break gives one frame error
                        // and not a stream of zero bytes.
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rdy       = rdy_q;
    assign dout      = dout_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
